// File: rtl/wireframe_rasterizer_if.sv
// Frame-buffer write bus for the wireframe rasterizer.
//   write_en    : pixel write valid (rasterizer -> sink)
//   write_ready : sink can accept a write this cycle (sink -> rasterizer)
//   addr        : linear pixel address y*SCREEN_W + x
//   wf_data     : pixel value
// master = rasterizer side, slave = frame-buffer side.
interface wireframe_rasterizer_if #(
  parameter int ADDR_W  = 17,
  parameter int PIXEL_W = 1
);
  logic               write_en;
  logic               write_ready;
  logic [ADDR_W-1:0]  addr;
  logic [PIXEL_W-1:0] wf_data;

  modport master (output write_en, output addr, output wf_data, input write_ready);
  modport slave  (input write_en, input addr, input wf_data, output write_ready);
endinterface

// File: rtl/wireframe_rasterizer.sv
// Triangle wireframe rasterizer: draws the three edges v0->v1, v1->v2,
// v2->v0 with Bresenham's algorithm and emits one frame-buffer write per
// on-screen pixel. Off-screen pixels are skipped in one cycle each.
// Ports:
//   clk, n_rst        : clock, asynchronous active-low reset
//   start             : draw request, only honoured in IDLE
//   v0_x..v2_y        : signed vertex coordinates, latched on start
//   i_color           : pixel value, latched on start
//   fb (master)       : write_en / write_ready / addr / wf_data bus
//   busy              : triangle in progress (SETUP and DRAW)
//   done              : one-cycle completion pulse
module wireframe_rasterizer #(
  parameter int SCREEN_W = 320,
  parameter int SCREEN_H = 240,
  parameter int COORD_W  = 12,
  parameter int PIXEL_W  = 1,
  parameter int ADDR_W   = $clog2(SCREEN_W*SCREEN_H)
) (
  input  logic                      clk,
  input  logic                      n_rst,
  input  logic                      start,
  input  logic signed [COORD_W-1:0] v0_x,
  input  logic signed [COORD_W-1:0] v0_y,
  input  logic signed [COORD_W-1:0] v1_x,
  input  logic signed [COORD_W-1:0] v1_y,
  input  logic signed [COORD_W-1:0] v2_x,
  input  logic signed [COORD_W-1:0] v2_y,
  input  logic [PIXEL_W-1:0]        i_color,
  output logic                      busy,
  output logic                      done,
  wireframe_rasterizer_if.master    fb
);
  // Two extra bits: |delta| of two COORD_W values needs COORD_W+1 bits
  // unsigned, and 2*err must still fit as a signed value.
  localparam int EW = COORD_W + 2;
  localparam logic signed [EW-1:0] ZERO_S = '0;
  localparam logic signed [EW-1:0] ONE_S  = EW'(1);
  localparam logic signed [EW-1:0] M1_S   = '1;
  localparam logic signed [EW-1:0] W_S    = EW'(SCREEN_W);
  localparam logic signed [EW-1:0] H_S    = EW'(SCREEN_H);

  typedef enum logic [1:0] {IDLE, SETUP, DRAW, DONE} state_t;

  state_t                    state_reg;
  logic signed [COORD_W-1:0] vx_reg [3];
  logic signed [COORD_W-1:0] vy_reg [3];
  logic [PIXEL_W-1:0]        color_reg;
  logic [1:0]                edge_reg;
  logic signed [EW-1:0]      cur_x_reg, cur_y_reg, end_x_reg, end_y_reg;
  logic signed [EW-1:0]      dx_reg, dy_reg, err_reg, sx_reg, sy_reg;
  logic                      write_en_reg, busy_reg, done_reg;
  logic [ADDR_W-1:0]         addr_reg;

  logic signed [EW-1:0] a_x, a_y, b_x, b_y, diff_x, diff_y;
  logic signed [EW-1:0] abs_dx, neg_dy, step_sx, step_sy;
  logic signed [EW-1:0] e2, next_x, next_y, next_err, pt_x, pt_y;
  logic                 step_x, step_y, at_end, consume, pt_on;
  logic [ADDR_W-1:0]    pt_addr;

  always_comb begin
    // Edge endpoints for the current edge index
    a_x = EW'(vx_reg[2]);
    a_y = EW'(vy_reg[2]);
    b_x = EW'(vx_reg[0]);
    b_y = EW'(vy_reg[0]);
    case (edge_reg)
      2'd0: begin
        a_x = EW'(vx_reg[0]); a_y = EW'(vy_reg[0]);
        b_x = EW'(vx_reg[1]); b_y = EW'(vy_reg[1]);
      end
      2'd1: begin
        a_x = EW'(vx_reg[1]); a_y = EW'(vy_reg[1]);
        b_x = EW'(vx_reg[2]); b_y = EW'(vy_reg[2]);
      end
      default: ;
    endcase
    diff_x  = b_x - a_x;
    diff_y  = b_y - a_y;
    abs_dx  = diff_x[EW-1] ? -diff_x : diff_x;
    neg_dy  = diff_y[EW-1] ? diff_y : -diff_y;
    step_sx = diff_x[EW-1] ? M1_S : ONE_S;
    step_sy = diff_y[EW-1] ? M1_S : ONE_S;

    // Bresenham step; both tests use the error before this step
    e2       = err_reg <<< 1;
    step_x   = (e2 >= dy_reg);
    step_y   = (e2 <= dx_reg);
    next_x   = cur_x_reg + (step_x ? sx_reg : ZERO_S);
    next_y   = cur_y_reg + (step_y ? sy_reg : ZERO_S);
    next_err = err_reg + (step_x ? dy_reg : ZERO_S) + (step_y ? dx_reg : ZERO_S);

    at_end  = (cur_x_reg == end_x_reg) && (cur_y_reg == end_y_reg);
    // A clipped pixel (write_en low while drawing) is consumed at once
    consume = write_en_reg ? fb.write_ready : 1'b1;

    // Pixel that will be presented next: the edge start in SETUP,
    // otherwise the stepped position
    pt_x    = (state_reg == SETUP) ? a_x : next_x;
    pt_y    = (state_reg == SETUP) ? a_y : next_y;
    pt_on   = (pt_x >= ZERO_S) && (pt_x < W_S) && (pt_y >= ZERO_S) && (pt_y < H_S);
    pt_addr = ADDR_W'(pt_y) * ADDR_W'(SCREEN_W) + ADDR_W'(pt_x);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_reg <= IDLE;
      for (int i = 0; i < 3; i++) begin
        vx_reg[i] <= '0;
        vy_reg[i] <= '0;
      end
      color_reg    <= '0;
      edge_reg     <= '0;
      cur_x_reg    <= '0;
      cur_y_reg    <= '0;
      end_x_reg    <= '0;
      end_y_reg    <= '0;
      dx_reg       <= '0;
      dy_reg       <= '0;
      err_reg      <= '0;
      sx_reg       <= '0;
      sy_reg       <= '0;
      write_en_reg <= 1'b0;
      addr_reg     <= '0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          done_reg     <= 1'b0;
          write_en_reg <= 1'b0;
          if (start) begin
            vx_reg[0] <= v0_x; vy_reg[0] <= v0_y;
            vx_reg[1] <= v1_x; vy_reg[1] <= v1_y;
            vx_reg[2] <= v2_x; vy_reg[2] <= v2_y;
            color_reg <= i_color;
            edge_reg  <= 2'd0;
            busy_reg  <= 1'b1;
            state_reg <= SETUP;
          end
        end
        SETUP: begin
          cur_x_reg    <= a_x;
          cur_y_reg    <= a_y;
          end_x_reg    <= b_x;
          end_y_reg    <= b_y;
          dx_reg       <= abs_dx;
          dy_reg       <= neg_dy;
          err_reg      <= abs_dx + neg_dy;
          sx_reg       <= step_sx;
          sy_reg       <= step_sy;
          write_en_reg <= pt_on;
          addr_reg     <= pt_addr;
          state_reg    <= DRAW;
        end
        DRAW: begin
          if (consume) begin
            if (at_end) begin
              write_en_reg <= 1'b0;
              if (edge_reg == 2'd2) begin
                busy_reg  <= 1'b0;
                done_reg  <= 1'b1;
                state_reg <= DONE;
              end else begin
                edge_reg  <= edge_reg + 2'd1;
                state_reg <= SETUP;
              end
            end else begin
              cur_x_reg    <= next_x;
              cur_y_reg    <= next_y;
              err_reg      <= next_err;
              write_en_reg <= pt_on;
              addr_reg     <= pt_addr;
            end
          end
        end
        DONE: begin
          done_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign fb.write_en = write_en_reg;
  assign fb.addr     = addr_reg;
  assign fb.wf_data  = color_reg;
  assign busy        = busy_reg;
  assign done        = done_reg;
endmodule

// File: tb/tb_wireframe_rasterizer.sv
module tb_wireframe_rasterizer;
  localparam int SW = 320;
  localparam int SH = 240;
  localparam int CW = 12;
  localparam int PW = 1;
  localparam int AW = $clog2(SW*SH);

  logic                 clk = 1'b0;
  logic                 n_rst = 1'b1;
  logic                 start = 1'b0;
  logic signed [CW-1:0] v0_x = '0, v0_y = '0, v1_x = '0, v1_y = '0, v2_x = '0, v2_y = '0;
  logic [PW-1:0]        i_color = '0;
  logic                 busy, done;

  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int exp_addr[$];
  int got_addr[$];
  int total_px;
  int first_cyc;

  wireframe_rasterizer_if #(.ADDR_W(AW), .PIXEL_W(PW)) fb ();

  wireframe_rasterizer #(
    .SCREEN_W(SW), .SCREEN_H(SH), .COORD_W(CW), .PIXEL_W(PW), .ADDR_W(AW)
  ) dut (
    .clk(clk), .n_rst(n_rst), .start(start),
    .v0_x(v0_x), .v0_y(v0_y), .v1_x(v1_x), .v1_y(v1_y), .v2_x(v2_x), .v2_y(v2_y),
    .i_color(i_color), .busy(busy), .done(done), .fb(fb)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Reference: walk every edge pixel by pixel, keep on-screen addresses and
  // the cycle offset (from the start cycle) of the first on-screen pixel
  // when the sink is always ready.
  task automatic build_model(input int x0, input int y0, input int x1, input int y1,
                             input int x2, input int y2);
    int xs[3];
    int ys[3];
    int off;
    xs = '{x0, x1, x2};
    ys = '{y0, y1, y2};
    exp_addr.delete();
    total_px  = 0;
    first_cyc = -1;
    off = 2;
    for (int e = 0; e < 3; e++) begin
      int xa, ya, xb, yb, dx, dy, sx, sy, err, x, y, n;
      bit fin;
      xa = xs[e]; ya = ys[e]; xb = xs[(e+1)%3]; yb = ys[(e+1)%3];
      dx = (xb > xa) ? xb - xa : xa - xb;
      dy = (yb > ya) ? ya - yb : yb - ya;
      sx = (xb < xa) ? -1 : 1;
      sy = (yb < ya) ? -1 : 1;
      err = dx + dy; x = xa; y = ya; n = 0; fin = 0;
      while (!fin) begin
        if (x >= 0 && x < SW && y >= 0 && y < SH) begin
          exp_addr.push_back(y*SW + x);
          if (first_cyc < 0) first_cyc = off + n;
        end
        n++;
        if (x == xb && y == yb) fin = 1;
        else begin
          int e2;
          e2 = 2*err;
          if (e2 >= dy) begin err += dy; x += sx; end
          if (e2 <= dx) begin err += dx; y += sy; end
        end
      end
      total_px += n;
      off += n + 1;
    end
  endtask

  function automatic logic ready_for(input int mode, input int k);
    if (mode == 1) return (k % 2 == 0);
    if (mode == 2) return ($urandom_range(3) != 0);
    return 1'b1;
  endfunction

  // rmode: 0 = always ready, 1 = toggling 1,0,1,0, 2 = random
  task automatic run_tri(input string name, input int x0, input int y0, input int x1,
                         input int y1, input int x2, input int y2, input logic [PW-1:0] col,
                         input int rmode, input bit hold_start, input bit poke);
    int t0, k, gi, first_we, done_cyc, stalls, budget;
    bit prev_stall;
    logic [AW-1:0] prev_addr;
    build_model(x0, y0, x1, y1, x2, y2);
    got_addr.delete();
    budget = 4*total_px + 40;
    @(posedge clk); #1;
    v0_x = CW'(x0); v0_y = CW'(y0); v1_x = CW'(x1); v1_y = CW'(y1);
    v2_x = CW'(x2); v2_y = CW'(y2);
    i_color = col;
    start = 1'b1;
    fb.write_ready = ready_for(rmode, 0);
    t0 = cyc;
    k = 0; gi = 0; first_we = -1; done_cyc = -1; stalls = 0; prev_stall = 0; prev_addr = '0;
    while (done_cyc < 0 && k < budget) begin
      @(negedge clk);
      if (k == 0) check({name, ":busy_start_cycle"}, 32'(busy), 32'd0);
      if (k == 1) check({name, ":busy_setup"}, 32'(busy), 32'd1);
      if (prev_stall) begin
        check({name, ":stall_hold_we"}, 32'(fb.write_en), 32'd1);
        check({name, ":stall_hold_addr"}, 32'(fb.addr), 32'(prev_addr));
      end
      if (fb.write_en) begin
        if (first_we < 0) first_we = k;
        if (fb.write_ready) begin
          if (gi < exp_addr.size())
            check($sformatf("%s:addr[%0d]", name, gi), 32'(fb.addr), 32'(exp_addr[gi]));
          else
            check({name, ":extra_write"}, 32'(gi), 32'(exp_addr.size()));
          check({name, ":wf_data"}, 32'(fb.wf_data), 32'(col));
          got_addr.push_back(int'(fb.addr));
          gi++;
        end else stalls++;
      end
      prev_stall = fb.write_en && !fb.write_ready;
      prev_addr  = fb.addr;
      if (done) begin
        done_cyc = k;
        check({name, ":busy_in_done"}, 32'(busy), 32'd0);
      end
      k++;
      @(posedge clk); #1;
      start = hold_start || (poke && (k == 3 || k == 6));
      if (k == 1) begin
        v0_x = CW'($urandom); v0_y = CW'($urandom); v1_x = CW'($urandom);
        v1_y = CW'($urandom); v2_x = CW'($urandom); v2_y = CW'($urandom);
        i_color = PW'($urandom);
      end
      fb.write_ready = ready_for(rmode, k);
    end
    start = 1'b0;
    fb.write_ready = 1'b1;
    check({name, ":done_seen"}, 32'(done_cyc >= 0), 32'd1);
    check({name, ":write_count"}, 32'(gi), 32'(exp_addr.size()));
    check({name, ":done_cycle"}, 32'(done_cyc), 32'(total_px + 4 + stalls));
    if (rmode == 0) check({name, ":first_we_cycle"}, 32'(first_we), 32'(first_cyc));
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      if (j == 0) check({name, ":done_one_cycle"}, 32'(done), 32'd0);
      check({name, ":idle_busy"}, 32'(busy), 32'd0);
      check({name, ":idle_we"}, 32'(fb.write_en), 32'd0);
      @(posedge clk); #1;
    end
    $display("tri %s: writes=%0d expected=%0d stalls=%0d done_at=+%0d", name, gi,
             exp_addr.size(), stalls, done_cyc);
  endtask

  initial begin
    int t0;
    int ref033[12];
    ref033 = '{0, 1, 2, 3, 3, 322, 641, 960, 960, 640, 320, 0};
    fb.write_ready = 1'b1;
    #1 n_rst = 1'b0;
    #1;
    check("reset:write_en", 32'(fb.write_en), 32'd0);
    check("reset:addr", 32'(fb.addr), 32'd0);
    check("reset:wf_data", 32'(fb.wf_data), 32'd0);
    check("reset:busy", 32'(busy), 32'd0);
    check("reset:done", 32'(done), 32'd0);
    repeat (3) @(posedge clk);
    #1 n_rst = 1'b1;

    run_tri("basic", 0, 0, 3, 0, 0, 3, 1'b1, 0, 0, 0);
    for (int i = 0; i < 12; i++)
      if (i < got_addr.size())
        check($sformatf("basic:const_addr[%0d]", i), 32'(got_addr[i]), 32'(ref033[i]));
    check("basic:const_count", 32'(got_addr.size()), 32'd12);

    run_tri("toggle", 0, 0, 3, 0, 0, 3, 1'b1, 1, 0, 0);
    run_tri("degenerate", 5, 5, 5, 5, 5, 5, 1'b1, 0, 0, 0);
    run_tri("clip", -2, 0, 1, 0, 1, 0, 1'b1, 0, 0, 0);
    run_tri("poke_busy", 10, 20, 40, 5, 25, 60, 1'b1, 2, 0, 1);
    run_tri("hold_start", 300, 230, 330, 250, 310, 200, 1'b1, 0, 1, 0);

    // Reset during the second edge aborts the triangle
    @(posedge clk); #1;
    v0_x = 0; v0_y = 0; v1_x = 3; v1_y = 0; v2_x = 0; v2_y = 3;
    i_color = 1'b1; start = 1'b1; fb.write_ready = 1'b1;
    t0 = cyc;
    repeat (8) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    check("abort:in_e1_we", 32'(fb.write_en), 32'd1);
    check("abort:in_e1_addr", 32'(fb.addr), 32'd322);
    check("abort:cycle", 32'(cyc - t0), 32'd8);
    #2 n_rst = 1'b0;
    #1;
    check("abort:write_en", 32'(fb.write_en), 32'd0);
    check("abort:addr", 32'(fb.addr), 32'd0);
    check("abort:wf_data", 32'(fb.wf_data), 32'd0);
    check("abort:busy", 32'(busy), 32'd0);
    check("abort:done", 32'(done), 32'd0);
    repeat (2) @(posedge clk);
    #1 n_rst = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      check("abort:quiet_we", 32'(fb.write_en), 32'd0);
      check("abort:quiet_busy", 32'(busy), 32'd0);
    end
    run_tri("after_reset", 0, 0, 3, 0, 0, 3, 1'b1, 0, 0, 0);

    for (int i = 0; i < 8; i++) begin
      int rx[3], ry[3];
      for (int v = 0; v < 3; v++) begin
        rx[v] = int'($urandom_range(380)) - 30;
        ry[v] = int'($urandom_range(300)) - 30;
      end
      run_tri($sformatf("rand%0d", i), rx[0], ry[0], rx[1], ry[1], rx[2], ry[2],
              PW'($urandom), 2, 0, (i % 2) == 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
